// File: rtl/apb_pkg.sv
// Shared APB definitions: master FSM states, response codes, select-width helper.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    localparam logic [1:0] RSP_OK      = 2'b00;
    localparam logic [1:0] RSP_SLVERR  = 2'b01;
    localparam logic [1:0] RSP_TIMEOUT = 2'b10;
    localparam logic [1:0] RSP_DECERR  = 2'b11;

    // Number of upper address bits needed to pick one of n slaves (at least 1).
    function automatic int sel_width(input int unsigned n);
        if (n <= 32'd1) return 1;
        return $clog2(n);
    endfunction

endpackage

// File: rtl/apb_slave_decode.sv
// Slave-select decode and return-path mux for an APB segment of NUM_SLV slaves.
module apb_slave_decode
    import apb_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned NUM_SLV = 2,
    localparam int unsigned SEL_W  = sel_width(NUM_SLV)
) (
    input  logic [SEL_W-1:0]          sel_bits,
    input  logic [SEL_W-1:0]          mux_idx,
    input  logic [NUM_SLV*DATA_W-1:0] prdata,
    input  logic [NUM_SLV-1:0]        pready,
    input  logic [NUM_SLV-1:0]        pslverr,
    output logic                      hit_c,
    output logic [NUM_SLV-1:0]        sel_c,
    output logic [DATA_W-1:0]         rdata_c,
    output logic                      ready_c,
    output logic                      slverr_c
);

    // Address bits to one-hot select; out-of-range indices decode to no slave.
    always_comb begin
        hit_c = (32'(sel_bits) < NUM_SLV);
        sel_c = '0;
        for (int i = 0; i < int'(NUM_SLV); i++) begin
            sel_c[i] = (sel_bits == SEL_W'(i));
        end
    end

    // Return-path mux: only the indexed slave's data, ready and error are visible.
    always_comb begin
        rdata_c  = '0;
        ready_c  = 1'b0;
        slverr_c = 1'b0;
        for (int i = 0; i < int'(NUM_SLV); i++) begin
            if (mux_idx == SEL_W'(i)) begin
                rdata_c  = prdata[i*DATA_W +: DATA_W];
                ready_c  = pready[i];
                slverr_c = pslverr[i];
            end
        end
    end

endmodule

// File: rtl/apb_master_n.sv
// APB master: valid/ready request port to APB transfers on NUM_SLV slaves,
// with PREADY timeout and one response per request.
module apb_master_n
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned NUM_SLV = 2,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                      PCLK,
    input  logic                      PRESET,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic [DATA_W-1:0]         req_wdata,
    output logic                      rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic [1:0]                rsp_err,
    output logic [NUM_SLV-1:0]        PSEL,
    output logic                      PENABLE,
    output logic                      PWRITE,
    output logic [ADDR_W-1:0]         PADDR,
    output logic [DATA_W-1:0]         PWDATA,
    input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
    input  logic [NUM_SLV-1:0]        PREADY,
    input  logic [NUM_SLV-1:0]        PSLVERR
);

    localparam int unsigned SEL_W   = sel_width(NUM_SLV);
    localparam int unsigned CNT_W   = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    state_t               state;
    logic [SEL_W-1:0]     sel_idx;
    logic [CNT_W-1:0]     cnt;
    logic [SEL_W-1:0]     req_sel_bits;
    logic                 dec_hit_c;
    logic [NUM_SLV-1:0]   dec_sel_c;
    logic [DATA_W-1:0]    slv_rdata_c;
    logic                 slv_ready_c;
    logic                 slv_err_c;

    assign req_sel_bits = req_addr[ADDR_W-1 -: SEL_W];

    apb_slave_decode #(
        .DATA_W  (DATA_W),
        .NUM_SLV (NUM_SLV)
    ) u_decode (
        .sel_bits (req_sel_bits),
        .mux_idx  (sel_idx),
        .prdata   (PRDATA),
        .pready   (PREADY),
        .pslverr  (PSLVERR),
        .hit_c    (dec_hit_c),
        .sel_c    (dec_sel_c),
        .rdata_c  (slv_rdata_c),
        .ready_c  (slv_ready_c),
        .slverr_c (slv_err_c)
    );

    // Transfer FSM with timeout counter; every output is a register.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state     <= IDLE;
            sel_idx   <= '0;
            cnt       <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= RSP_OK;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        PADDR  <= req_addr;
                        PWRITE <= req_write;
                        PWDATA <= req_wdata;
                        if (dec_hit_c) begin
                            state     <= SETUP;
                            req_ready <= 1'b0;
                            PSEL      <= dec_sel_c;
                            sel_idx   <= req_sel_bits;
                            cnt       <= '0;
                        end else begin
                            // No slave behind this address: answer without bus activity.
                            rsp_valid <= 1'b1;
                            rsp_err   <= RSP_DECERR;
                            rsp_rdata <= '0;
                        end
                    end
                end
                SETUP: begin
                    state   <= ACCESS;
                    PENABLE <= 1'b1;
                end
                ACCESS: begin
                    if (slv_ready_c) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                        PSEL      <= '0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= slv_err_c ? RSP_SLVERR : RSP_OK;
                        rsp_rdata <= (!PWRITE && !slv_err_c) ? slv_rdata_c : '0;
                    end else if ((TIMEOUT != 0) && (cnt == CNT_W'(TO_LAST))) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                        PSEL      <= '0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= RSP_TIMEOUT;
                        rsp_rdata <= '0;
                    end else if (cnt != CNT_W'(TIMEOUT)) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    PSEL    <= '0;
                    PENABLE <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_n.sv
// Directed bench for apb_master_n: instance a (2 slaves, TIMEOUT 4), instance b (3 slaves).
module tb_apb_master_n;

    logic        pclk;
    logic        preset;
    int          checks;
    int          errors;

    logic        a_req_valid, a_req_ready, a_req_write;
    logic [7:0]  a_req_addr, a_req_wdata;
    logic        a_rsp_valid;
    logic [7:0]  a_rsp_rdata;
    logic [1:0]  a_rsp_err;
    logic [1:0]  a_psel;
    logic        a_penable, a_pwrite;
    logic [7:0]  a_paddr, a_pwdata;
    logic [15:0] a_prdata;
    logic [1:0]  a_pready, a_pslverr;

    logic        b_req_valid, b_req_ready, b_req_write;
    logic [7:0]  b_req_addr, b_req_wdata;
    logic        b_rsp_valid;
    logic [7:0]  b_rsp_rdata;
    logic [1:0]  b_rsp_err;
    logic [2:0]  b_psel;
    logic        b_penable, b_pwrite;
    logic [7:0]  b_paddr, b_pwdata;
    logic [23:0] b_prdata;
    logic [2:0]  b_pready, b_pslverr;

    apb_master_n #(.ADDR_W(8), .DATA_W(8), .NUM_SLV(2), .TIMEOUT(4)) dut_a (
        .PCLK(pclk), .PRESET(preset),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
        .PSEL(a_psel), .PENABLE(a_penable), .PWRITE(a_pwrite), .PADDR(a_paddr), .PWDATA(a_pwdata),
        .PRDATA(a_prdata), .PREADY(a_pready), .PSLVERR(a_pslverr)
    );

    apb_master_n #(.ADDR_W(8), .DATA_W(8), .NUM_SLV(3), .TIMEOUT(15)) dut_b (
        .PCLK(pclk), .PRESET(preset),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
        .PSEL(b_psel), .PENABLE(b_penable), .PWRITE(b_pwrite), .PADDR(b_paddr), .PWDATA(b_pwdata),
        .PRDATA(b_prdata), .PREADY(b_pready), .PSLVERR(b_pslverr)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic test_reset();
        preset = 1'b0;
        #3;
        checks++; if (a_req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready got %b exp 0", a_req_ready); end
        checks++; if (a_rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %b exp 0", a_rsp_valid); end
        checks++; if (a_psel !== 2'b00) begin errors++; $display("FAIL rst_psel got %b exp 00", a_psel); end
        checks++; if (a_penable !== 1'b0) begin errors++; $display("FAIL rst_penable got %b exp 0", a_penable); end
        checks++; if ({a_paddr, a_pwdata, a_pwrite} !== 17'h0) begin errors++; $display("FAIL rst_bus got %h exp 0", {a_paddr, a_pwdata, a_pwrite}); end
        checks++; if ({a_rsp_rdata, a_rsp_err} !== 10'h0) begin errors++; $display("FAIL rst_rsp got %h exp 0", {a_rsp_rdata, a_rsp_err}); end
        checks++; if (b_psel !== 3'b000) begin errors++; $display("FAIL rst_b_psel got %b exp 000", b_psel); end
        repeat (2) @(posedge pclk);
        #2 preset = 1'b1;
        tick();
        checks++; if (a_req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after got %b exp 1", a_req_ready); end
        checks++; if (b_req_ready !== 1'b1) begin errors++; $display("FAIL rst_b_ready_after got %b exp 1", b_req_ready); end
    endtask

    task automatic test_write();
        a_pready = 2'b11; a_pslverr = 2'b00; a_prdata = 16'hEEDD;
        a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 8'h85; a_req_wdata = 8'hA5;
        checks++; if (a_req_ready !== 1'b1) begin errors++; $display("FAIL wr_ready_c0 got %b exp 1", a_req_ready); end
        tick(); // cycle 1: SETUP
        a_req_valid = 1'b0; a_req_wdata = 8'h00; a_req_addr = 8'h00;
        checks++; if (a_psel !== 2'b10) begin errors++; $display("FAIL wr_psel_c1 got %b exp 10", a_psel); end
        checks++; if (a_penable !== 1'b0) begin errors++; $display("FAIL wr_penable_c1 got %b exp 0", a_penable); end
        checks++; if ({a_pwrite, a_paddr, a_pwdata} !== {1'b1, 8'h85, 8'hA5}) begin errors++; $display("FAIL wr_bus_c1 got %h exp 185a5", {a_pwrite, a_paddr, a_pwdata}); end
        checks++; if (a_req_ready !== 1'b0) begin errors++; $display("FAIL wr_ready_c1 got %b exp 0", a_req_ready); end
        tick(); // cycle 2: ACCESS
        checks++; if ({a_psel, a_penable} !== 3'b101) begin errors++; $display("FAIL wr_psel_pen_c2 got %b exp 101", {a_psel, a_penable}); end
        checks++; if (a_pwdata !== 8'hA5) begin errors++; $display("FAIL wr_pwdata_c2 got %h exp a5", a_pwdata); end
        checks++; if (a_rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_rsp_c2 got %b exp 0", a_rsp_valid); end
        tick(); // cycle 3: response
        checks++; if (a_rsp_valid !== 1'b1) begin errors++; $display("FAIL wr_rsp_valid_c3 got %b exp 1", a_rsp_valid); end
        checks++; if ({a_rsp_err, a_rsp_rdata} !== 10'h000) begin errors++; $display("FAIL wr_rsp_c3 got %h exp 000", {a_rsp_err, a_rsp_rdata}); end
        checks++; if ({a_psel, a_penable, a_req_ready} !== 4'b0001) begin errors++; $display("FAIL wr_idle_c3 got %b exp 0001", {a_psel, a_penable, a_req_ready}); end
        checks++; if (a_pwdata !== 8'hA5) begin errors++; $display("FAIL wr_pwdata_hold got %h exp a5", a_pwdata); end
        tick();
        checks++; if (a_rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_rsp_pulse got %b exp 0", a_rsp_valid); end
    endtask

    task automatic test_read_wait();
        a_pready = 2'b10; a_pslverr = 2'b10; a_prdata = 16'hFF3C;
        a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 8'h12; a_req_wdata = 8'h99;
        tick(); // cycle 1
        a_req_valid = 1'b0;
        checks++; if ({a_psel, a_penable} !== 3'b010) begin errors++; $display("FAIL rd_setup_c1 got %b exp 010", {a_psel, a_penable}); end
        tick(); // cycle 2
        checks++; if ({a_psel, a_penable} !== 3'b011) begin errors++; $display("FAIL rd_access_c2 got %b exp 011", {a_psel, a_penable}); end
        tick();
        tick(); // cycle 4
        checks++; if ({a_psel, a_penable, a_rsp_valid} !== 4'b0110) begin errors++; $display("FAIL rd_wait_c4 got %b exp 0110", {a_psel, a_penable, a_rsp_valid}); end
        tick(); // cycle 5
        a_pready = 2'b01; a_pslverr = 2'b00;
        checks++; if (a_rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_rsp_c5 got %b exp 0", a_rsp_valid); end
        tick(); // cycle 6
        checks++; if (a_rsp_valid !== 1'b1) begin errors++; $display("FAIL rd_rsp_valid_c6 got %b exp 1", a_rsp_valid); end
        checks++; if (a_rsp_rdata !== 8'h3C) begin errors++; $display("FAIL rd_rdata_c6 got %h exp 3c", a_rsp_rdata); end
        checks++; if (a_rsp_err !== 2'b00) begin errors++; $display("FAIL rd_err_c6 got %b exp 00", a_rsp_err); end
        checks++; if ({a_paddr, a_pwrite} !== {8'h12, 1'b0}) begin errors++; $display("FAIL rd_bus_hold got %h exp 024", {a_paddr, a_pwrite}); end
    endtask

    task automatic test_slverr();
        a_pready = 2'b10; a_pslverr = 2'b10; a_prdata = 16'h7700;
        a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 8'h90;
        tick();
        a_req_valid = 1'b0;
        tick();
        tick(); // cycle 3
        checks++; if (a_rsp_valid !== 1'b1) begin errors++; $display("FAIL se_rsp_valid got %b exp 1", a_rsp_valid); end
        checks++; if (a_rsp_err !== 2'b01) begin errors++; $display("FAIL se_err got %b exp 01", a_rsp_err); end
        checks++; if (a_rsp_rdata !== 8'h00) begin errors++; $display("FAIL se_rdata got %h exp 00", a_rsp_rdata); end
    endtask

    task automatic test_timeout();
        a_pready = 2'b00; a_pslverr = 2'b00; a_prdata = 16'h4455;
        a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 8'h05;
        tick(); // cycle 1
        a_req_valid = 1'b0;
        tick(); // cycle 2: first ACCESS
        checks++; if (a_penable !== 1'b1) begin errors++; $display("FAIL to_penable_c2 got %b exp 1", a_penable); end
        tick();
        tick();
        tick(); // cycle 5: fourth ACCESS
        checks++; if ({a_psel, a_penable, a_rsp_valid} !== 4'b0110) begin errors++; $display("FAIL to_access_c5 got %b exp 0110", {a_psel, a_penable, a_rsp_valid}); end
        tick(); // cycle 6
        checks++; if ({a_psel, a_penable} !== 3'b000) begin errors++; $display("FAIL to_drop_c6 got %b exp 000", {a_psel, a_penable}); end
        checks++; if ({a_rsp_valid, a_rsp_err} !== 3'b110) begin errors++; $display("FAIL to_rsp_c6 got %b exp 110", {a_rsp_valid, a_rsp_err}); end
        checks++; if (a_rsp_rdata !== 8'h00) begin errors++; $display("FAIL to_rdata_c6 got %h exp 00", a_rsp_rdata); end
        checks++; if (a_req_ready !== 1'b1) begin errors++; $display("FAIL to_ready_c6 got %b exp 1", a_req_ready); end
        a_pready = 2'b10;
        a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 8'h81; a_req_wdata = 8'h3E;
        tick(); // cycle 7: next request already in SETUP
        a_req_valid = 1'b0;
        checks++; if ({a_psel, a_penable} !== 3'b100) begin errors++; $display("FAIL to_next_setup got %b exp 100", {a_psel, a_penable}); end
        checks++; if ({a_paddr, a_pwdata} !== 16'h813E) begin errors++; $display("FAIL to_next_bus got %h exp 813e", {a_paddr, a_pwdata}); end
        tick();
        tick();
        checks++; if ({a_rsp_valid, a_rsp_err} !== 3'b100) begin errors++; $display("FAIL to_next_rsp got %b exp 100", {a_rsp_valid, a_rsp_err}); end
    endtask

    task automatic test_back_to_back();
        b_pready = 3'b100; b_pslverr = 3'b000; b_prdata = 24'h5A1122;
        b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = 8'hC0;
        checks++; if (b_req_ready !== 1'b1) begin errors++; $display("FAIL de_ready_c0 got %b exp 1", b_req_ready); end
        tick(); // cycle 1
        checks++; if ({b_rsp_valid, b_rsp_err} !== 3'b111) begin errors++; $display("FAIL de_rsp_c1 got %b exp 111", {b_rsp_valid, b_rsp_err}); end
        checks++; if ({b_psel, b_penable} !== 4'b0000) begin errors++; $display("FAIL de_nobus_c1 got %b exp 0000", {b_psel, b_penable}); end
        checks++; if (b_req_ready !== 1'b1) begin errors++; $display("FAIL de_ready_c1 got %b exp 1", b_req_ready); end
        checks++; if (b_paddr !== 8'hC0) begin errors++; $display("FAIL de_paddr_c1 got %h exp c0", b_paddr); end
        b_req_addr = 8'hC5;
        tick(); // cycle 2
        checks++; if ({b_rsp_valid, b_rsp_err, b_psel} !== 6'b111000) begin errors++; $display("FAIL de_rsp_c2 got %b exp 111000", {b_rsp_valid, b_rsp_err, b_psel}); end
        b_req_addr = 8'h80;
        tick(); // cycle 3: valid slave 2
        b_req_valid = 1'b0;
        checks++; if ({b_rsp_valid, b_psel, b_penable} !== 5'b01000) begin errors++; $display("FAIL b2_setup got %b exp 01000", {b_rsp_valid, b_psel, b_penable}); end
        tick();
        tick(); // cycle 5
        checks++; if ({b_rsp_valid, b_rsp_err} !== 3'b100) begin errors++; $display("FAIL b2_rsp got %b exp 100", {b_rsp_valid, b_rsp_err}); end
        checks++; if (b_rsp_rdata !== 8'h5A) begin errors++; $display("FAIL b2_rdata got %h exp 5a", b_rsp_rdata); end
    endtask

    task automatic test_reset_mid();
        logic seen;
        a_pready = 2'b00; a_pslverr = 2'b00;
        a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 8'h00;
        tick();
        a_req_valid = 1'b0;
        tick(); // cycle 2: ACCESS
        checks++; if ({a_psel, a_penable} !== 3'b011) begin errors++; $display("FAIL rm_access got %b exp 011", {a_psel, a_penable}); end
        #2 preset = 1'b0;
        #1;
        checks++; if ({a_psel, a_penable} !== 3'b000) begin errors++; $display("FAIL rm_async_drop got %b exp 000", {a_psel, a_penable}); end
        checks++; if ({a_req_ready, a_rsp_valid, a_paddr, a_pwdata} !== 18'h0) begin errors++; $display("FAIL rm_outputs got %h exp 0", {a_req_ready, a_rsp_valid, a_paddr, a_pwdata}); end
        #2 preset = 1'b1;
        a_pready = 2'b11;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            seen = seen | a_rsp_valid;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rm_no_rsp got %b exp 0", seen); end
        checks++; if ({a_req_ready, a_psel} !== 3'b100) begin errors++; $display("FAIL rm_idle_after got %b exp 100", {a_req_ready, a_psel}); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        a_req_valid = 1'b0; a_req_write = 1'b0; a_req_addr = 8'h00; a_req_wdata = 8'h00;
        a_prdata = 16'h0; a_pready = 2'b00; a_pslverr = 2'b00;
        b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = 8'h00; b_req_wdata = 8'h00;
        b_prdata = 24'h0; b_pready = 3'b000; b_pslverr = 3'b000;
        test_reset();
        test_write();
        test_read_wait();
        test_slverr();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
